// File: rtl/sa_ctrl_pkg.sv
// Shared geometry, widths and FSM state encoding for the systolic-array controller.
package sa_ctrl_pkg;

  localparam int ARRAY_ROW  = 12;
  localparam int ARRAY_COL  = 12;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 32;
  localparam int SEQ_W      = 16;

  // Wide enough to count the weight-load phase up to ARRAY_ROW+1.
  localparam int CNT_W = $clog2(ARRAY_ROW + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/sa_skew_line.sv
// Per-lane delay line: lane i is delayed i cycles (ASCENDING) or LANES-1-i cycles.
module sa_skew_line #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter bit ASCENDING = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] data,
  output logic [LANES*WIDTH-1:0] skewed
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int DEPTH = ASCENDING ? i : LANES - 1 - i;

    if (DEPTH == 0) begin : g_pass
      assign skewed[i*WIDTH +: WIDTH] = data[i*WIDTH +: WIDTH];
    end else begin : g_dly
      logic [WIDTH-1:0] sr [DEPTH];

      // NOTE: these stages are cleared on reset (unlike a RAM) so an aborted job
      // leaves no stale operands or psums in flight; all stages shift with <=.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else begin
          sr[0] <= data[i*WIDTH +: WIDTH];
          for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
      end

      assign skewed[i*WIDTH +: WIDTH] = sr[DEPTH-1];
    end
  end

endmodule

// File: rtl/sa_ctrl.sv
// Systolic-array job controller: weight load, skewed activation stream, de-skewed results.
// Optional busy-cycle counter on perf_cycles is built only when SA_CTRL_PERF_EN is defined.
module sa_ctrl
  import sa_ctrl_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [SEQ_W-1:0]                seq_len,
  output logic                            busy,
  output logic                            done,
  output logic                            w_rd_en,
  output logic [3:0]                      w_rd_addr,
  input  logic [ARRAY_COL*DATA_WIDTH-1:0] w_rd_data,
  output logic                            a_rd_en,
  output logic [SEQ_W-1:0]                a_rd_addr,
  input  logic [ARRAY_ROW*DATA_WIDTH-1:0] a_rd_data,
  output logic [ARRAY_ROW-1:0]            row_load_en,
  output logic [ARRAY_COL*DATA_WIDTH-1:0] in_weight_vec,
  output logic                            en_compute,
  output logic [ARRAY_ROW*DATA_WIDTH-1:0] in_act_vec,
  input  logic [ARRAY_COL*ACC_WIDTH-1:0]  out_psum_vec,
  output logic                            res_valid,
  output logic [ARRAY_COL*ACC_WIDTH-1:0]  res_data,
  output logic [SEQ_W-1:0]                res_idx,
  output logic [31:0]                     perf_cycles
);

  // A read issued at cycle k reaches the result port R+C cycles later.
  localparam int VLD_DEPTH = ARRAY_ROW + ARRAY_COL;
  localparam logic [ARRAY_ROW-1:0] ROW_ONE = {{(ARRAY_ROW-1){1'b0}}, 1'b1};

  logic [2:0]                      state;
  logic [SEQ_W-1:0]                len_q;
  logic [SEQ_W-1:0]                a_cnt;
  logic [SEQ_W-1:0]                res_cnt;
  logic [CNT_W-1:0]                w_cnt;
  logic [CNT_W-1:0]                w_row_q;
  logic                            w_vld_q;
  logic                            act_vld_q;
  logic [VLD_DEPTH-1:0]            vld_pipe;
  logic [ARRAY_ROW*DATA_WIDTH-1:0] act_gated;
  logic [ARRAY_COL*ACC_WIDTH-1:0]  psum_aligned;
  logic                            accept;
  logic                            last_res;

  assign accept     = (state == S_IDLE) && start;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign en_compute = (state == S_STREAM) || (state == S_DRAIN);

  assign w_rd_en   = (state == S_LOAD_W) && (w_cnt < CNT_W'(ARRAY_ROW));
  assign w_rd_addr = w_rd_en ? 4'(w_cnt) : 4'd0;
  assign a_rd_en   = (state == S_STREAM);
  assign a_rd_addr = a_rd_en ? a_cnt : '0;

  assign row_load_en   = w_vld_q ? (ROW_ONE << w_row_q) : '0;
  assign in_weight_vec = w_vld_q ? w_rd_data : '0;
  assign act_gated     = act_vld_q ? a_rd_data : '0;

  assign res_valid = vld_pipe[VLD_DEPTH-1];
  assign res_data  = res_valid ? psum_aligned : '0;
  assign res_idx   = res_valid ? res_cnt : '0;
  assign last_res  = res_valid && (res_cnt == len_q - SEQ_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      len_q <= '0;
      w_cnt <= '0;
      a_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= seq_len;
            w_cnt <= '0;
            a_cnt <= '0;
            state <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          w_cnt <= w_cnt + CNT_W'(1);
          // An empty job lingers one extra cycle so done lands at the fixed slot.
          if (len_q != '0 && w_cnt == CNT_W'(ARRAY_ROW))
            state <= S_STREAM;
          else if (len_q == '0 && w_cnt == CNT_W'(ARRAY_ROW + 1))
            state <= S_DONE;
        end
        S_STREAM: begin
          a_cnt <= a_cnt + SEQ_W'(1);
          if (a_cnt == len_q - SEQ_W'(1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_res) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_vld_q   <= 1'b0;
      w_row_q   <= '0;
      act_vld_q <= 1'b0;
      vld_pipe  <= '0;
      res_cnt   <= '0;
    end else begin
      w_vld_q   <= w_rd_en;
      w_row_q   <= w_cnt;
      act_vld_q <= a_rd_en;
      vld_pipe  <= {vld_pipe[VLD_DEPTH-2:0], a_rd_en};
      if (accept)
        res_cnt <= '0;
      else if (res_valid)
        res_cnt <= res_cnt + SEQ_W'(1);
    end
  end

  sa_skew_line #(
    .LANES    (ARRAY_ROW),
    .WIDTH    (DATA_WIDTH),
    .ASCENDING(1'b1)
  ) u_skew (
    .clk   (clk),
    .rst   (rst),
    .data  (act_gated),
    .skewed(in_act_vec)
  );

  sa_skew_line #(
    .LANES    (ARRAY_COL),
    .WIDTH    (ACC_WIDTH),
    .ASCENDING(1'b0)
  ) u_deskew (
    .clk   (clk),
    .rst   (rst),
    .data  (out_psum_vec),
    .skewed(psum_aligned)
  );

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_q;

  // The accepting cycle itself is counted, so a job reports its full occupancy.
  always_ff @(posedge clk) begin
    if (rst)
      perf_q <= '0;
    else if (accept)
      perf_q <= 32'd1;
    else if (busy && perf_q != '1)
      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl with behavioural weight/activation memories and a systolic-array model.
module tb_sa_ctrl;
  import sa_ctrl_pkg::*;

  localparam int R    = ARRAY_ROW;
  localparam int C    = ARRAY_COL;
  localparam int DW   = DATA_WIDTH;
  localparam int AW   = ACC_WIDTH;
  localparam int HIST = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [SEQ_W-1:0]    seq_len = '0;
  logic                busy, done, w_rd_en, a_rd_en, en_compute, res_valid;
  logic [3:0]          w_rd_addr;
  logic [SEQ_W-1:0]    a_rd_addr, res_idx;
  logic [C*DW-1:0]     w_rd_data = '0;
  logic [R*DW-1:0]     a_rd_data = '0;
  logic [R-1:0]        row_load_en;
  logic [C*DW-1:0]     in_weight_vec;
  logic [R*DW-1:0]     in_act_vec;
  logic [C*AW-1:0]     out_psum_vec = '0;
  logic [C*AW-1:0]     res_data;
  logic [31:0]         perf_cycles;

  sa_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .row_load_en(row_load_en), .in_weight_vec(in_weight_vec),
    .en_compute(en_compute), .in_act_vec(in_act_vec), .out_psum_vec(out_psum_vec),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [DW-1:0]   wmat [R][C];
  logic [DW-1:0]   amat [64][R];
  logic [DW-1:0]   lw   [R][C];
  logic [R*DW-1:0] hist [HIST];

  int              b_cyc [$];
  logic [SEQ_W-1:0] b_idx [$];
  logic [C*AW-1:0] b_data [$];
  int done_cnt, done_k, rl_cnt, rl_err, rd_err, en_cnt, en_first, en_last;
  logic [31:0] perf_end;
  logic        idle_after_rst;

  // Memories answer one cycle after the read enable.
  always @(posedge clk) begin
    if (w_rd_en)
      for (int c = 0; c < C; c++) w_rd_data[c*DW +: DW] <= wmat[w_rd_addr][c];
    if (a_rd_en)
      for (int r = 0; r < R; r++) a_rd_data[r*DW +: DW] <= amat[a_rd_addr[5:0]][r];
  end

  // Array model: column c at cycle n sums row r's lane as it stood at cycle n-R-c+r.
  always @(negedge clk) begin
    hist[cyc % HIST] = in_act_vec;
    for (int r = 0; r < R; r++)
      if (row_load_en[r])
        for (int c = 0; c < C; c++) lw[r][c] = in_weight_vec[c*DW +: DW];
  end

  initial begin
    for (int i = 0; i < HIST; i++) hist[i] = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) lw[r][c] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int c = 0; c < C; c++) begin
        logic [AW-1:0] acc;
        acc = '0;
        for (int r = 0; r < R; r++) begin
          int idx;
          idx = cyc - R - c + r;
          if (idx >= 0) acc += AW'(lw[r][c]) * AW'(hist[idx % HIST][r*DW +: DW]);
        end
        out_psum_vec[c*AW +: AW] = acc;
      end
    end
  end

  function automatic logic [C*AW-1:0] golden(input int t);
    logic [C*AW-1:0] v;
    logic [AW-1:0]   acc;
    v = '0;
    for (int c = 0; c < C; c++) begin
      acc = '0;
      for (int r = 0; r < R; r++) acc += AW'(amat[t][r]) * AW'(wmat[r][c]);
      v[c*AW +: AW] = acc;
    end
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wmat[r][c] = DW'($urandom);
    for (int t = 0; t < 64; t++)
      for (int r = 0; r < R; r++) amat[t][r] = DW'($urandom);
  endtask

  // Runs one job from an accepted start (cycle 0), logging outputs cycle by cycle.
  task automatic run_job(input int len, input int rst_at, input int again_at);
    logic [C*DW-1:0] wexp;
    b_cyc.delete(); b_idx.delete(); b_data.delete();
    done_cnt = 0; done_k = -1; rl_cnt = 0; rl_err = 0; rd_err = 0;
    en_cnt = 0; en_first = -1; en_last = -1; perf_end = '0; idle_after_rst = 1'b0;
    @(negedge clk);
    seq_len = SEQ_W'(len);
    start   = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (res_valid) begin
        b_cyc.push_back(k); b_idx.push_back(res_idx); b_data.push_back(res_data);
      end
      if (done) begin done_cnt++; done_k = k; end
      if (en_compute) begin en_cnt++; if (en_first < 0) en_first = k; en_last = k; end
      if (w_rd_en && w_rd_addr !== 4'(k - 1)) rd_err++;
      if (a_rd_en && a_rd_addr !== SEQ_W'(k - 14)) rd_err++;
      if (row_load_en !== '0) begin
        rl_cnt++;
        if (k - 2 < 0 || k - 2 >= R) rl_err++;
        else begin
          for (int c = 0; c < C; c++) wexp[c*DW +: DW] = wmat[k-2][c];
          if (row_load_en !== (R'(1) << (k - 2)) || in_weight_vec !== wexp) rl_err++;
        end
      end
      if (rst_at >= 0 && k == rst_at + 1) idle_after_rst = !busy;
      if (done_cnt > 0 && k == done_k + 1) perf_end = perf_cycles;
      if (rst_at < 0 && done_cnt > 0 && k >= done_k + 2) break;
      if (rst_at >= 0 && k >= rst_at + 60) break;
      @(negedge clk);
      start = (k + 1 == again_at);
      rst   = (k + 1 == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_run++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_run++; if (en_compute !== 1'b0) begin n_fail++; $display("FAIL reset_en_compute: got %b want 0", en_compute); end
    n_run++; if (row_load_en !== '0) begin n_fail++; $display("FAIL reset_row_load_en: got %h want 0", row_load_en); end
    n_run++; if (in_act_vec !== '0) begin n_fail++; $display("FAIL reset_in_act_vec: got %h want 0", in_act_vec); end
    n_run++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d want 0", perf_cycles); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    logic [C*AW-1:0] ones;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wmat[r][c] = (r == c) ? 8'd1 : 8'd0;
    for (int r = 0; r < R; r++) amat[0][r] = 8'h01;
    for (int c = 0; c < C; c++) ones[c*AW +: AW] = 32'd1;
    run_job(1, -1, -1);
    n_run++; if (b_cyc.size() !== 1) begin n_fail++; $display("FAIL ident_beats: got %0d want 1", b_cyc.size()); end
    if (b_cyc.size() > 0) begin
      n_run++; if (b_cyc[0] !== 38) begin n_fail++; $display("FAIL ident_cycle: got %0d want 38", b_cyc[0]); end
      n_run++; if (b_idx[0] !== '0) begin n_fail++; $display("FAIL ident_idx: got %0d want 0", b_idx[0]); end
      n_run++; if (b_data[0] !== ones) begin n_fail++; $display("FAIL ident_data: got %h want %h", b_data[0], ones); end
    end
    n_run++; if (done_cnt !== 1 || done_k !== 39) begin n_fail++; $display("FAIL ident_done: got %0d pulses at %0d want 1 at 39", done_cnt, done_k); end
    n_run++; if (rl_cnt !== 12 || rl_err !== 0) begin n_fail++; $display("FAIL ident_row_load: got %0d pulses %0d bad want 12 and 0", rl_cnt, rl_err); end
    n_run++; if (rd_err !== 0) begin n_fail++; $display("FAIL ident_rd_addr: got %0d bad reads want 0", rd_err); end
    n_run++; if (en_first !== 14 || en_last !== 38) begin n_fail++; $display("FAIL ident_en_compute: got %0d..%0d want 14..38", en_first, en_last); end
  endtask

  task automatic test_random();
    fill_random();
    run_job(32, -1, -1);
    n_run++; if (b_cyc.size() !== 32) begin n_fail++; $display("FAIL rand_beats: got %0d want 32", b_cyc.size()); end
    for (int i = 0; i < b_cyc.size() && i < 32; i++) begin
      n_run++;
      if (b_cyc[i] !== 38 + i || b_idx[i] !== SEQ_W'(i) || b_data[i] !== golden(i)) begin
        n_fail++;
        $display("FAIL rand_beat%0d: got cyc %0d idx %0d data %h want cyc %0d idx %0d data %h",
                 i, b_cyc[i], b_idx[i], b_data[i], 38 + i, i, golden(i));
      end
    end
    n_run++; if (done_cnt !== 1 || done_k !== 70) begin n_fail++; $display("FAIL rand_done: got %0d pulses at %0d want 1 at 70", done_cnt, done_k); end
    n_run++; if (rd_err !== 0) begin n_fail++; $display("FAIL rand_rd_addr: got %0d bad reads want 0", rd_err); end
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_job(32, -1, 20);
    n_run++; if (done_cnt !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    n_run++; if (done_k !== 70) begin n_fail++; $display("FAIL restart_done_cycle: got %0d want 70", done_k); end
    n_run++; if (b_cyc.size() !== 32) begin n_fail++; $display("FAIL restart_beats: got %0d want 32", b_cyc.size()); end
  endtask

  task automatic test_zero_len();
    fill_random();
    run_job(0, -1, -1);
    n_run++; if (rl_cnt !== 12 || rl_err !== 0) begin n_fail++; $display("FAIL zero_row_load: got %0d pulses %0d bad want 12 and 0", rl_cnt, rl_err); end
    n_run++; if (done_cnt !== 1 || done_k !== 15) begin n_fail++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at 15", done_cnt, done_k); end
    n_run++; if (b_cyc.size() !== 0) begin n_fail++; $display("FAIL zero_res_valid: got %0d beats want 0", b_cyc.size()); end
    n_run++; if (en_cnt !== 0) begin n_fail++; $display("FAIL zero_en_compute: got %0d cycles want 0", en_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] perf_exp;
    fill_random();
    run_job(32, 25, -1);
    n_run++; if (idle_after_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got busy=%b want busy=0", !idle_after_rst); end
    n_run++; if (b_cyc.size() !== 0 || done_cnt !== 0) begin n_fail++; $display("FAIL midrst_stale: got %0d beats %0d done want 0 and 0", b_cyc.size(), done_cnt); end
    fill_random();
    run_job(4, -1, -1);
    n_run++; if (b_cyc.size() !== 4) begin n_fail++; $display("FAIL midrst_beats: got %0d want 4", b_cyc.size()); end
    for (int i = 0; i < b_cyc.size() && i < 4; i++) begin
      n_run++;
      if (b_cyc[i] !== 38 + i || b_idx[i] !== SEQ_W'(i) || b_data[i] !== golden(i)) begin
        n_fail++;
        $display("FAIL midrst_beat%0d: got cyc %0d idx %0d data %h want cyc %0d idx %0d data %h",
                 i, b_cyc[i], b_idx[i], b_data[i], 38 + i, i, golden(i));
      end
    end
    n_run++; if (done_k !== 42) begin n_fail++; $display("FAIL midrst_done: got %0d want 42", done_k); end
`ifdef SA_CTRL_PERF_EN
    perf_exp = 32'd43;
`else
    perf_exp = 32'd0;
`endif
    n_run++; if (perf_end !== perf_exp) begin n_fail++; $display("FAIL midrst_perf: got %0d want %0d", perf_end, perf_exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_random();
    test_start_ignored();
    test_zero_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
